// File: rtl/rv32_mod_csr_access.sv
// Zicsr sequencer: privilege/read-only checks, then read, modify and write the CSR file; returns old value.
// Latency: 3 cycles legal RMW, 2 read-suppressed, 1 illegal. Backpressure: response held in RESP until resp_ready.
// Optional macro RV32_CSR_RO_CHECK_EN makes writes to read-only CSRs (addr[11:10]==2'b11) illegal.
module rv32_mod_csr_access #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      priviledge,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_uimm,
  input  logic            req_rd_zero,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal,
  output logic [11:0]     csr_addr,
  output logic            csr_re,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_wdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] src_q, src_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            illegal_q, illegal_d;
  logic            rsup_q, rsup_d;
  logic            wsup_q, wsup_d;

  // Decode of the incoming request, used only at acceptance.
  logic            in_bad_f3, in_rsup, in_wsup, in_priv_bad, in_ro_bad, in_illegal;
  logic [XLEN-1:0] old_val, new_val;

  always_comb begin
    in_bad_f3   = (req_funct3[1:0] == 2'b00);
    in_rsup     = (req_funct3[1:0] == 2'b01) && req_rd_zero;
    in_wsup     = req_funct3[1] && (req_uimm == 5'd0);
    in_priv_bad = (req_addr[9:8] > priviledge);
`ifdef RV32_CSR_RO_CHECK_EN
    in_ro_bad   = !in_wsup && (req_addr[11:10] == 2'b11);
`else
    in_ro_bad   = 1'b0;
`endif
    in_illegal  = in_bad_f3 || in_priv_bad || in_ro_bad;
  end

  always_comb begin
    old_val = rsup_q ? '0 : csr_rdata;
    case (op_q)
      2'b01:   new_val = src_q;
      2'b10:   new_val = old_val | src_q;
      default: new_val = old_val & ~src_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    src_d     = src_q;
    rdata_d   = rdata_q;
    illegal_d = illegal_q;
    rsup_d    = rsup_q;
    wsup_d    = wsup_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d      = req_funct3[1:0];
          addr_d    = req_addr;
          src_d     = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_uimm} : req_rs1_val;
          rdata_d   = '0;
          illegal_d = in_illegal;
          rsup_d    = in_rsup;
          wsup_d    = in_wsup;
          if (in_illegal)   state_d = RESP;
          else if (in_rsup) state_d = WR;
          else              state_d = RD;
        end
      end
      RD: state_d = WR;
      WR: begin
        rdata_d = old_val;
        state_d = RESP;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      addr_q    <= '0;
      src_q     <= '0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
      rsup_q    <= 1'b0;
      wsup_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      src_q     <= src_d;
      rdata_q   <= rdata_d;
      illegal_q <= illegal_d;
      rsup_q    <= rsup_d;
      wsup_q    <= wsup_d;
    end
  end

  // Strobes are decoded from state so they pulse exactly once and never overlap.
  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = rdata_q;
  assign resp_illegal = illegal_q;
  assign csr_addr     = addr_q;
  assign csr_re       = (state_q == RD);
  assign csr_we       = (state_q == WR) && !wsup_q;
  assign csr_wdata    = (state_q == WR) ? new_val : '0;

endmodule

// File: tb/tb_rv32_mod_csr_access.sv
// Directed bench for rv32_mod_csr_access; inputs driven and outputs sampled on the falling clock edge.
module tb_rv32_mod_csr_access;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      priviledge;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_rs1_val;
  logic [4:0]      req_uimm;
  logic            req_rd_zero;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;
  logic [11:0]     csr_addr;
  logic            csr_re;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_we;
  logic [XLEN-1:0] csr_wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rv32_mod_csr_access #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .priviledge(priviledge),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1_val(req_rs1_val), .req_uimm(req_uimm),
    .req_rd_zero(req_rd_zero), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_illegal(resp_illegal), .csr_addr(csr_addr),
    .csr_re(csr_re), .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_wdata(csr_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobes(input string tag, input logic re, input logic we);
    check({tag, "_re"}, {31'd0, csr_re}, {31'd0, re});
    check({tag, "_we"}, {31'd0, csr_we}, {31'd0, we});
  endtask

  task automatic resp(input string tag, input logic [31:0] rdata, input logic ill);
    check({tag, "_vld"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_rdata"}, resp_rdata, rdata);
    check({tag, "_ill"}, {31'd0, resp_illegal}, {31'd0, ill});
    strobes(tag, 1'b0, 1'b0);
  endtask

  // Present a request at a falling edge; it is accepted on the following rising edge (edge T).
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                       input logic [4:0] uimm, input logic rdz, input logic [1:0] priv);
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_rs1_val = rs1;
    req_uimm = uimm; req_rd_zero = rdz; priviledge = priv;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Take the response and confirm the block returns to IDLE the next cycle.
  task automatic take(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_idle_rdy"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_idle_vld"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; priviledge = 2'd3; req_valid = 1'b0; req_funct3 = 3'd0; req_addr = 12'h0;
    req_rs1_val = '0; req_uimm = 5'd0; req_rd_zero = 1'b0; resp_ready = 1'b0; csr_rdata = '0;
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_ill", {31'd0, resp_illegal}, 32'd0);
    strobes("rst", 1'b0, 1'b0);
    check("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
    check("rst_csr_wdata", csr_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // CSRRS 0x300, M-mode: old 0x1800 | 0x8
    csr_rdata = 32'h1800;
    issue(3'b010, 12'h300, 32'h8, 5'd5, 1'b0, 2'd3);
    strobes("rs_t1", 1'b1, 1'b0);
    check("rs_t1_addr", {20'd0, csr_addr}, 32'h300);
    @(negedge clk);
    strobes("rs_t2", 1'b0, 1'b1);
    check("rs_t2_wdata", csr_wdata, 32'h1808);
    @(negedge clk);
    resp("rs_t3", 32'h1800, 1'b0);
    take("rs");

    // CSRRW rd=x0: no read, write in T+1, rdata 0
    csr_rdata = 32'h5555;
    issue(3'b001, 12'h340, 32'hDEAD, 5'd7, 1'b1, 2'd3);
    strobes("rw0_t1", 1'b0, 1'b1);
    check("rw0_t1_wdata", csr_wdata, 32'hDEAD);
    check("rw0_t1_addr", {20'd0, csr_addr}, 32'h340);
    @(negedge clk);
    resp("rw0_t2", 32'h0, 1'b0);
    take("rw0");

    // CSRRSI zimm=0 on read-only counter in U-mode: read only
    csr_rdata = 32'hABCD;
    issue(3'b110, 12'hC00, 32'hFFFF, 5'd0, 1'b0, 2'd0);
    strobes("rsi_t1", 1'b1, 1'b0);
    @(negedge clk);
    strobes("rsi_t2", 1'b0, 1'b0);
    @(negedge clk);
    resp("rsi_t3", 32'hABCD, 1'b0);
    take("rsi");

    // CSRRC to M-mode CSR from U-mode: privilege violation
    issue(3'b011, 12'h300, 32'h1, 5'd5, 1'b0, 2'd0);
    resp("priv_t1", 32'h0, 1'b1);
    take("priv");

    // Reserved funct3
    issue(3'b100, 12'h340, 32'h1, 5'd5, 1'b0, 2'd3);
    resp("f3_t1", 32'h0, 1'b1);
    take("f3");

    // CSRRW to read-only mhartid
    csr_rdata = 32'h0;
    issue(3'b001, 12'hF11, 32'h1, 5'd1, 1'b0, 2'd3);
`ifdef RV32_CSR_RO_CHECK_EN
    resp("ro_t1", 32'h0, 1'b1);
`else
    strobes("ro_t1", 1'b1, 1'b0);
    @(negedge clk);
    strobes("ro_t2", 1'b0, 1'b1);
    check("ro_t2_wdata", csr_wdata, 32'h1);
    @(negedge clk);
    resp("ro_t3", 32'h0, 1'b0);
`endif
    take("ro");

    // Reset asserted while in RD
    csr_rdata = 32'h1234;
    issue(3'b010, 12'h300, 32'h8, 5'd5, 1'b0, 2'd3);
    strobes("rstrd_t1", 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    strobes("rstrd_async", 1'b0, 1'b0);
    check("rstrd_rdy", {31'd0, req_ready}, 32'd1);
    check("rstrd_vld", {31'd0, resp_valid}, 32'd0);
    check("rstrd_addr", {20'd0, csr_addr}, 32'd0);
    check("rstrd_wdata", csr_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      strobes("rstrd_after", 1'b0, 1'b0);
      check("rstrd_after_vld", {31'd0, resp_valid}, 32'd0);
    end

    // Response stall: outputs held while resp_ready stays low
    csr_rdata = 32'h99;
    issue(3'b001, 12'h340, 32'h77, 5'd3, 1'b0, 2'd3);
    strobes("st_t1", 1'b1, 1'b0);
    @(negedge clk);
    strobes("st_t2", 1'b0, 1'b1);
    check("st_t2_wdata", csr_wdata, 32'h77);
    @(negedge clk);
    csr_rdata = 32'hBAD;
    for (int i = 0; i < 5; i++) begin
      resp("st_hold", 32'h99, 1'b0);
      check("st_hold_rdy", {31'd0, req_ready}, 32'd0);
      check("st_hold_addr", {20'd0, csr_addr}, 32'h340);
      @(negedge clk);
    end
    resp("st_last", 32'h99, 1'b0);
    take("st");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rv32_mod_csr_access.md
# rv32_mod_csr_access

CSR instruction sequencer for the rv32imc single-stage core. It sits between decode/execute and the CSR register file. It accepts one decoded Zicsr instruction at a time and checks privilege and read-only rules. It then performs the architecturally required read and/or write on the CSR file and returns the old CSR value for rd, or an illegal-instruction flag.

## Interface
Parameters:
- XLEN, 32, data width of CSR values and rs1 operand.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- priviledge  in  2  current privilege level (0=U, 1=S, 3=M); sampled at request acceptance.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_funct3  in  3  Zicsr funct3.
- req_addr  in  12  CSR address.
- req_rs1_val  in  XLEN  rs1 register value (register forms).
- req_uimm  in  5  zimm field (immediate forms); also the rs1 index for the x0 check.
- req_rd_zero  in  1  rd == x0.
- resp_valid  out  1  response held until taken.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  XLEN  old CSR value to write to rd.
- resp_illegal  out  1  raise illegal-instruction trap; resp_rdata is 0 when set.
- csr_addr  out  12  address to CSR file; holds the latched request address.
- csr_re  out  1  one-cycle read strobe.
- csr_rdata  in  XLEN  CSR file read data, valid the cycle after csr_re.
- csr_we  out  1  one-cycle write strobe.
- csr_wdata  out  XLEN  write data.

## Operation
- funct3 decode:
  - 001 CSRRW, 010 CSRRS, 011 CSRRC: source = req_rs1_val.
  - 101/110/111: immediate forms; source = zero-extended req_uimm.
  - 000/100: illegal.
- Read suppression: read is suppressed for CSRRW/CSRRWI with req_rd_zero=1. In that case resp_rdata=0.
- Write suppression: write is suppressed for the S/C forms when req_uimm==0. This covers both rs1=x0 and zimm=0.
- New value:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
- Illegal conditions, evaluated at acceptance from latched fields:
  - bad funct3;
  - req_addr[9:8] > priviledge;
  - a write will occur and req_addr[11:10]==2'b11 (see Configuration).
- An illegal request issues no csr_re and no csr_we.
- FSM states:
  - IDLE: on req_valid, latch the request and go to:
    - RESP if illegal;
    - WR if the read is suppressed;
    - RD otherwise.
  - RD: csr_re=1. Next state WR.
  - WR: capture csr_rdata (or 0 if the read was suppressed) into resp_rdata. csr_we=1 with csr_wdata=new value, unless the write is suppressed. Next state RESP.
  - RESP: resp_valid=1. When resp_ready=1, go to IDLE.
- Outputs stay stable throughout RESP.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_illegal=0, csr_re=0, csr_we=0, csr_addr=0, csr_wdata=0.
- Request accepted at edge T (req_valid & req_ready):
  - csr_re is high in cycle T+1;
  - csr_we is high in cycle T+2;
  - resp_valid rises in cycle T+3.
- Read-suppressed requests: csr_we in T+1, resp_valid in T+2.
- Illegal requests: resp_valid in T+1.
- Back-to-back: resp taken at edge R gives req_ready=1 in cycle R+1. Minimum issue interval is 4 cycles for legal RMW.
- csr_re and csr_we are never high in the same cycle. Each pulses for exactly one cycle per request.
- Reset asserted mid-operation: return to IDLE immediately and drop any pending strobes or response. A write already strobed stays committed.
- resp_ready held low: remain in RESP indefinitely with outputs unchanged.

## Configuration
- RV32_CSR_RO_CHECK_EN:
  - Defined: a write to req_addr[11:10]==2'b11 is illegal.
  - Undefined: the check is omitted and the write strobe is issued; the CSR file ignores it.
- Reads of read-only CSRs are legal in both builds.

## Test plan
- CSRRS, addr 0x300, priv=3, rs1_val=0x8, csr_rdata=0x1800:
  - csr_re in T+1;
  - csr_we in T+2 with wdata=0x1808;
  - resp_rdata=0x1800, resp_illegal=0 in T+3.
- CSRRW, rd=x0, addr 0x340, rs1_val=0xDEAD:
  - no csr_re;
  - csr_we in T+1 with wdata=0xDEAD;
  - resp_rdata=0 in T+2.
- CSRRSI, uimm=0, addr 0xC00, priv=0:
  - csr_re only, no csr_we;
  - resp_rdata equals csr_rdata.
- Illegal cases, each giving resp_illegal=1 in T+1 with no strobes:
  - CSRRC, addr 0x300, priv=0;
  - funct3=100.
- CSRRW to 0xF11, priv=3:
  - with RV32_CSR_RO_CHECK_EN: illegal;
  - without it: csr_we pulses.
- Reset during RD, and resp_ready held low for 5 cycles:
  - after reset, IDLE with all outputs at reset values and no csr_we;
  - during stall, resp outputs are held stable.
